// File: rtl/nioshello_pio_edge_ext.sv
// Avalon-MM parallel I/O port: synchronised inputs, edge capture with W1C, output set/clear aliases, level IRQ.
// Optional per-bit input debounce is built when PIO_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module nioshello_pio_edge_ext #(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] OUT_RESET       = '0,
    parameter int               DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_OUTREG   = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] clr_bits;
    logic [31:0]      rd_mux;

    assign wr           = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      db_cnt [WIDTH];
    logic [WIDTH-1:0] stable;

    // A bit only moves once sync has disagreed with it for DEBOUNCE_CYCLES straight cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
            stable <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign filt = stable;
`else
    assign filt = sync;
`endif

    always_comb begin
        if (EDGE_TYPE == 1)
            edge_det = filt & ~prev;
        else if (EDGE_TYPE == 2)
            edge_det = ~filt & prev;
        else
            edge_det = filt ^ prev;
    end

    assign clr_bits = (wr && address == ADDR_EDGE_CAP) ? wdata : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:     rd_mux[WIDTH-1:0] = filt;
            ADDR_OUTREG:   rd_mux[WIDTH-1:0] = out_port;
            ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_cap;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev     <= '0;
            edge_cap <= '0;
            irq_mask <= '0;
            out_port <= OUT_RESET;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            prev     <= filt;
            // A fresh edge wins over a same-cycle W1C so no event is ever lost.
            edge_cap <= edge_det | (edge_cap & ~clr_bits);
            irq      <= |(edge_cap & irq_mask);
            readdata <= rd_mux;
            if (wr) begin
                case (address)
                    ADDR_DATA, ADDR_OUTREG: out_port <= wdata;
                    ADDR_IRQ_MASK:          irq_mask <= wdata;
                    ADDR_OUTSET:            out_port <= out_port | wdata;
                    ADDR_OUTCLR:            out_port <= out_port & ~wdata;
                    default:                ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nioshello_pio_edge_ext.sv
// Directed bench for nioshello_pio_edge_ext: rising, any and falling edge variants share one bus.
`timescale 1ns/1ps
module tb_nioshello_pio_edge_ext;

`ifdef PIO_DEBOUNCE_EN
    localparam int DB_LAT = 16;
`else
    localparam int DB_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in_port = '0;

    logic [31:0] rd_rise, rd_any, rd_fall;
    logic        irq_rise, irq_any, irq_fall;
    logic [7:0]  out_rise, out_any, out_fall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nioshello_pio_edge_ext #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .OUT_RESET(8'hA5)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd_rise), .irq(irq_rise), .in_port(in_port), .out_port(out_rise));

    nioshello_pio_edge_ext #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .OUT_RESET(8'hA5)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd_any), .irq(irq_any), .in_port(in_port), .out_port(out_any));

    nioshello_pio_edge_ext #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .OUT_RESET(8'hA5)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd_fall), .irq(irq_fall), .in_port(in_port), .out_port(out_fall));

    typedef struct {
        bit          is_wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // Result is in rd_* at return: readdata registers one edge after the address.
    task automatic bus_read(input logic [2:0] a);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 32'h0000_000F, 8'h0F, 32'h0};
        vecs[1]  = '{1'b1, 3'd4, 32'h0000_00F0, 8'hFF, 32'h0};
        vecs[2]  = '{1'b1, 3'd5, 32'h0000_0081, 8'h7E, 32'h0};
        vecs[3]  = '{1'b0, 3'd4, 32'h0,         8'h7E, 32'h0};
        vecs[4]  = '{1'b0, 3'd1, 32'h0,         8'h7E, 32'h0000_007E};
        vecs[5]  = '{1'b1, 3'd0, 32'hFFFF_FF00, 8'h00, 32'h0};
        vecs[6]  = '{1'b0, 3'd5, 32'h0,         8'h00, 32'h0};
        vecs[7]  = '{1'b1, 3'd1, 32'h0000_003C, 8'h3C, 32'h0};
        vecs[8]  = '{1'b1, 3'd6, 32'h0000_00FF, 8'h3C, 32'h0};
        vecs[9]  = '{1'b1, 3'd2, 32'hABCD_0084, 8'h3C, 32'h0};
        vecs[10] = '{1'b0, 3'd2, 32'h0,         8'h3C, 32'h0000_0084};
        vecs[11] = '{1'b0, 3'd3, 32'h0,         8'h3C, 32'h0};
        vecs[12] = '{1'b1, 3'd7, 32'h0000_00FF, 8'h3C, 32'h0};
        vecs[13] = '{1'b0, 3'd7, 32'h0,         8'h3C, 32'h0};
        vecs[14] = '{1'b0, 3'd0, 32'h0,         8'h3C, 32'h0};

        // Reset and defaults, in_port held low throughout
        reset = 1'b1;
        wait_cyc(3);
        check("reset_out", {24'h0, out_rise}, 32'hA5);
        check("reset_irq", {31'h0, irq_rise | irq_any | irq_fall}, 32'h0);
        check("reset_rd", rd_rise, 32'h0);
        @(negedge clk) reset = 1'b0;
        wait_cyc(6 + DB_LAT);
        bus_read(3'd2); check("dflt_mask", rd_rise, 32'h0);
        bus_read(3'd3); check("dflt_cap_any", rd_any, 32'h0);
        bus_read(3'd1); check("dflt_outreg", rd_rise, 32'h0000_00A5);

        // Register map and output aliases
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr);
                check($sformatf("vec%0d_rd", i), rd_rise, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_out", i), {24'h0, out_any}, {24'h0, vecs[i].exp_out});
        end

        // Rising-edge capture timing, capture read through held address 3
        @(negedge clk) address = 3'd3;
        @(negedge clk) in_port = 8'h04;
        wait_cyc(3 + DB_LAT);
        check("rise_irq_early", {31'h0, irq_rise}, 32'h0);
        check("rise_cap_early", rd_rise, 32'h0);
        wait_cyc(1);
        check("rise_irq", {31'h0, irq_rise}, 32'h1);
        check("rise_cap", rd_rise, 32'h04);
        check("fall_irq_none", {31'h0, irq_fall}, 32'h0);
        bus_write(3'd3, 32'hFF);
        @(negedge clk) in_port = 8'h00;
        wait_cyc(6 + DB_LAT);
        bus_read(3'd3);
        check("rise_no_fall_cap", rd_rise, 32'h0);
        check("fall_cap", rd_fall, 32'h04);
        check("any_fall_cap", rd_any, 32'h04);
        bus_write(3'd3, 32'hFF);

        // W1C clears only written bits; a same-cycle edge wins
        @(negedge clk) in_port = 8'h06;
        wait_cyc(5 + DB_LAT);
        bus_read(3'd3); check("cap_06", rd_rise, 32'h06);
        check("irq_06", {31'h0, irq_rise}, 32'h1);
        bus_write(3'd3, 32'h02);
        bus_read(3'd3); check("w1c_partial", rd_rise, 32'h04);
        check("irq_after_w1c", {31'h0, irq_rise}, 32'h1);
        @(negedge clk) in_port = 8'h02;
        wait_cyc(5 + DB_LAT);
        bus_write(3'd3, 32'hFF);
        bus_read(3'd3); check("w1c_all", rd_rise, 32'h0);
        @(negedge clk) in_port = 8'h06;
        wait_cyc(2 + DB_LAT);
        address = 3'd3; writedata = 32'h04; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        bus_read(3'd3); check("edge_beats_w1c", rd_rise, 32'h04);

        // Any-edge: set, clear, re-set on the opposite toggle
        bus_write(3'd3, 32'hFF);
        @(negedge clk) in_port = 8'h86;
        wait_cyc(5 + DB_LAT);
        bus_read(3'd3); check("any_rise7", rd_any, 32'h80);
        check("any_irq7", {31'h0, irq_any}, 32'h1);
        bus_write(3'd3, 32'h80);
        bus_read(3'd3); check("any_clr7", rd_any, 32'h0);
        @(negedge clk) in_port = 8'h06;
        wait_cyc(5 + DB_LAT);
        bus_read(3'd3); check("any_fall7", rd_any, 32'h80);
        bus_read(3'd0); check("data_in", rd_rise, 32'h06);

        // Reset mid-operation with inputs already high
        bus_write(3'd0, 32'h5A);
        @(negedge clk) reset = 1'b1;
        wait_cyc(2);
        check("midrst_out", {24'h0, out_fall}, 32'hA5);
        check("midrst_irq", {31'h0, irq_any}, 32'h0);
        @(negedge clk) reset = 1'b0;
        wait_cyc(5 + DB_LAT);
        bus_read(3'd3); check("post_rst_rise", rd_rise, 32'h06);
        check("post_rst_fall", rd_fall, 32'h0);
        check("post_rst_irq", {31'h0, irq_rise}, 32'h0);
        bus_read(3'd2); check("post_rst_mask", rd_rise, 32'h0);

`ifdef PIO_DEBOUNCE_EN
        // Glitch shorter than the debounce window is invisible; a longer pulse lands
        bus_write(3'd3, 32'hFF);
        @(negedge clk) in_port = 8'h07;
        wait_cyc(10);
        in_port = 8'h06;
        wait_cyc(30);
        bus_read(3'd0); check("db_glitch_data", rd_rise, 32'h06);
        bus_read(3'd3); check("db_glitch_cap", rd_rise, 32'h0);
        @(negedge clk) in_port = 8'h07;
        wait_cyc(19);
        bus_read(3'd0); check("db_pulse_data", rd_rise, 32'h07);
        in_port = 8'h06;
        wait_cyc(40);
        bus_read(3'd3); check("db_pulse_cap", rd_rise, 32'h01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
